mul_hilo_sequencer: RTL
=======================

Name: mul_hilo_sequencer

Overview:
- Controller for the multicycle multiply path of the EX stage: MULTU, MADDU, MFHI and MFLO.
- Issues start, step and write-back strobes to the multiplier and the HI/LO registers.
- Selects the HI/LO source for the EX result mux.
- Stalls the pipeline whenever a multiply-class instruction meets a multiply still in flight.
- Other ALU and shifter ops continue unstalled in parallel.

Parameters:
- MUL_CYCLES, default 32: number of iteration cycles per multiply, one per multiplier bit; legal range 1..63.
- CNT_W, default 6: width of the iteration counter; must satisfy 2^CNT_W > MUL_CYCLES.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- ALUOp  input  2  EX-stage ALU op class; 2'b10 = R-type (funct valid)
- Signal  input  6  EX-stage funct field (MULTU=6'b011001, MADDU=6'b011100, MFHI=6'b010000, MFLO=6'b010010)
- nop  input  1  EX slot holds a bubble; instruction is ignored
- mul_start  output  1  load operands into the multiplier and clear the partial product
- mul_step  output  1  multiplier performs one iteration
- hilo_we  output  1  write the 64-bit multiplier result into HI/LO
- hilo_acc  output  1  qualifies hilo_we: 1 = accumulate into HI/LO (MADDU), 0 = overwrite (MULTU)
- mux_sel  output  2  EX result source: 00 = ALU/shifter, 01 = HI, 10 = LO
- stall  output  1  hold PC, IF/ID and ID/EX; EX instruction is re-presented next cycle
- busy  output  1  multiply in flight (state RUN or WB)
- cycle_cnt  output  CNT_W  current iteration index

Behaviour:
- Decode, combinational:
  - vld = (ALUOp==2'b10) && !nop.
  - is_mul = vld && funct in {MULTU, MADDU}.
  - is_mf = vld && funct in {MFHI, MFLO}.
  - Any other funct, or ALUOp!=10, has no effect on this block.
- States: IDLE, RUN, WB. busy = (state!=IDLE).
- stall = busy && (is_mul || is_mf), combinational. Non-multiply ops never stall.
- IDLE:
  - is_mul: mul_start=1 in the same cycle; latch acc_q = (funct==MADDU); cycle_cnt<=0; next state RUN.
  - is_mf: mux_sel=01 (MFHI) or 10 (MFLO) in the same cycle; no stall.
  - Otherwise mux_sel=00.
- RUN:
  - mul_step=1 every cycle.
  - cycle_cnt increments each cycle.
  - When cycle_cnt==MUL_CYCLES-1, next state is WB and cycle_cnt<=0.
- WB:
  - hilo_we=1 and hilo_acc=acc_q for exactly one cycle; next state IDLE.
  - An MFHI/MFLO present during WB is stalled, since HI/LO is updated at the end of this cycle.
- While stall=1, mux_sel=00. mul_start is asserted only in IDLE.
- Latency for a multiply accepted in cycle T:
  - RUN occupies T+1 .. T+MUL_CYCLES.
  - WB occurs at T+MUL_CYCLES+1.
  - A dependent MFHI/MFLO or a new multiply first proceeds at T+MUL_CYCLES+2.
- Back-to-back multiplies: the second is stalled until IDLE, then accepted with mul_start in that cycle. There is no dead cycle beyond WB.
- nop=1 during a stall: stall deasserts immediately. The sequence in flight continues unaffected.
- Reset (sync, active-high) has priority over everything:
  - state=IDLE, cycle_cnt=0, acc_q=0.
  - All outputs 0 in the cycle after reset is sampled; mux_sel=00.
  - Reset mid-RUN or in WB aborts the multiply. hilo_we never fires for it, so HI/LO keep their prior value.
- hilo_we and hilo_acc are functions of state only (Moore outputs).
- mul_start, stall and mux_sel depend combinationally on the EX inputs (Mealy outputs).

Test Plan:
- Reset, then MULTU presented in IDLE at cycle T:
  - mul_start=1 at T.
  - mul_step=1 for cycles T+1..T+32.
  - hilo_we=1, hilo_acc=0 only at T+33.
  - busy=0 at T+34.
- MULTU at T, then MFLO held in EX from T+1:
  - stall=1 for T+1..T+33.
  - At T+34: stall=0, mux_sel=10.
- MADDU at T, then ADD (funct 100000) at T+1:
  - stall=0 and mux_sel=00 at T+1.
  - hilo_acc=1 with hilo_we at T+33.
- Two MULTUs back-to-back:
  - Second is stalled T+1..T+33.
  - mul_start=1 at T+34; its hilo_we fires at T+67.
- reset asserted at T+10 of a MULTU:
  - busy=0 and cycle_cnt=0 from T+11.
  - No hilo_we pulse through T+40.
- MFHI with nop=1 while busy:
  - stall=0, mux_sel=00.
- With MUL_CYCLES=1: MULTU at T gives mul_step only at T+1 and hilo_we at T+2.

Source files
------------

// File: rtl/mul_hilo_sequencer.sv
// Sequencer for the EX-stage multicycle multiply path: MULTU/MADDU start,
// iterate and write back HI/LO; MFHI/MFLO select HI/LO or stall behind a busy multiply.
module mul_hilo_sequencer #(
  parameter int MUL_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       ALUOp,
  input  logic [5:0]       Signal,
  input  logic             nop,
  output logic             mul_start,
  output logic             mul_step,
  output logic             hilo_we,
  output logic             hilo_acc,
  output logic [1:0]       mux_sel,
  output logic             stall,
  output logic             busy,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_MADDU = 6'b011100;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MUL_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             acc_q, acc_d;

  logic vld, is_mul, is_mf;

  always_comb begin
    vld    = (ALUOp == 2'b10) && !nop;
    is_mul = vld && ((Signal == F_MULTU) || (Signal == F_MADDU));
    is_mf  = vld && ((Signal == F_MFHI) || (Signal == F_MFLO));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mul_start = 1'b0;
    mul_step  = 1'b0;
    hilo_we   = 1'b0;
    hilo_acc  = 1'b0;
    mux_sel   = 2'b00;
    busy      = (state_q != IDLE);
    // Only multiply-class instructions wait on the in-flight sequence.
    stall     = busy && (is_mul || is_mf);
    unique case (state_q)
      IDLE: begin
        if (is_mul) begin
          mul_start = 1'b1;
          acc_d     = (Signal == F_MADDU);
          cnt_d     = '0;
          state_d   = RUN;
        end else if (is_mf) begin
          mux_sel = (Signal == F_MFHI) ? 2'b01 : 2'b10;
        end
      end
      RUN: begin
        mul_step = 1'b1;
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          state_d = WB;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WB: begin
        // HI/LO is written at the end of this cycle, so readers were held above.
        hilo_we  = 1'b1;
        hilo_acc = acc_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cycle_cnt = cnt_q;

endmodule
